// File: rtl/pci_burst_addr_gen.sv
// PCI burst address generator: turns a PCI command, burst order and start address
// into a paced sequence of memory word addresses. Optional macro ADDR_PARITY_EN adds add_par.
module pci_burst_addr_gen #(
    parameter int ADDR_W     = 8,
    parameter int LINE_WORDS = 4,
    parameter int MULT_LINES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        cmd,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] local_address,
    input  logic              mem_ready,
    input  logic              abort,
    output logic [ADDR_W-1:0] add_2_mem,
    output logic              addr_valid,
    output logic              busy,
    output logic              done,
`ifdef ADDR_PARITY_EN
    output logic              add_par,
`endif
    output logic              err
);

    localparam int OFF_W     = $clog2(LINE_WORDS);
    localparam int MAX_BEATS = LINE_WORDS * MULT_LINES;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [OFF_W-1:0]   lineBeat_q, lineBeat_d;
    logic [OFF_W-1:0]   startOff_q, startOff_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
`ifdef ADDR_PARITY_EN
    logic [3:0]         cmd_q, cmd_d;
`endif

    logic               cmdLegal;
    logic [CNT_W-1:0]   burstLen;

    // Reserved burst orders (mode[0] set) collapse any legal command to a single beat.
    always_comb begin
        cmdLegal = 1'b1;
        burstLen = CNT_W'(1);
        case (cmd)
            4'b0110, 4'b0111: burstLen = CNT_W'(1);
            4'b1110, 4'b1111: burstLen = CNT_W'(LINE_WORDS);
            4'b1100:          burstLen = CNT_W'(MAX_BEATS);
            default:          cmdLegal = 1'b0;
        endcase
        if (mode[0]) begin
            burstLen = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            lineBeat_q <= '0;
            startOff_q <= '0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef ADDR_PARITY_EN
            cmd_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            lineBeat_q <= lineBeat_d;
            startOff_q <= startOff_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
`ifdef ADDR_PARITY_EN
            cmd_q      <= cmd_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        lineBeat_d = lineBeat_q;
        startOff_d = startOff_q;
        wrap_d     = wrap_q;
        err_d      = 1'b0;
`ifdef ADDR_PARITY_EN
        cmd_d      = cmd_q;
`endif
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (cmdLegal) begin
                        state_d    = BURST;
                        addr_d     = local_address;
                        remain_d   = burstLen;
                        lineBeat_d = '0;
                        startOff_d = local_address[OFF_W-1:0];
                        wrap_d     = (mode == 2'b10);
`ifdef ADDR_PARITY_EN
                        cmd_d      = cmd;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BURST: begin
                // Abort takes priority, so a beat offered in the same cycle is dropped.
                if (abort) begin
                    state_d = DONE;
                end else if (mem_ready) begin
                    if (remain_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        remain_d = remain_q - CNT_W'(1);
                        if (!wrap_q) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end else if (lineBeat_q == OFF_W'(LINE_WORDS - 1)) begin
                            addr_d     = {addr_q[ADDR_W-1:OFF_W] + 1'b1, startOff_q};
                            lineBeat_d = '0;
                        end else begin
                            addr_d     = {addr_q[ADDR_W-1:OFF_W], addr_q[OFF_W-1:0] + 1'b1};
                            lineBeat_d = lineBeat_q + OFF_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign add_2_mem  = addr_q;
    assign addr_valid = (state_q == BURST);
    assign busy       = (state_q == BURST) || (state_q == DONE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
`ifdef ADDR_PARITY_EN
    assign add_par    = addr_valid ? ^{addr_q, cmd_q} : 1'b0;
`endif

endmodule
